// File: rtl/mux_pkg.sv
// Shared definitions for the four-way registered multiplexer.
// Holds the select encodings, the 2-bit select type and the minimum legal
// data width used by the elaboration-time width check.
package mux_pkg;

   typedef enum logic [1:0] {
      SEL_A = 2'b00,
      SEL_B = 2'b01,
      SEL_C = 2'b10,
      SEL_D = 2'b11
   } sel_t;

   localparam int MIN_WIDTH = 1;

endpackage

// File: rtl/mux4_comb.sv
// Combinational 4:1 N-bit selector.
// Ports:
//   a, b, c, d : N-bit data words, chosen by s = SEL_A/SEL_B/SEL_C/SEL_D
//   s          : select code
//   y          : selected word, bit-for-bit copy of the chosen input
module mux4_comb
   import mux_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   input  logic [N-1:0] d,
   input  sel_t         s,
   output logic [N-1:0] y
);

   always_comb begin
      y = '0;
      unique case (s)
         SEL_A: y = a;
         SEL_B: y = b;
         SEL_C: y = c;
         SEL_D: y = d;
      endcase
   end

endmodule

// File: rtl/mux_nbit.sv
// Four-input N-bit multiplexer with a registered output.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset, clears Y and S_q
//   en         : load enable; 1 loads the selected word, 0 holds
//   A, B, C, D : N-bit data words for S = 00, 01, 10, 11
//   S          : select code
//   Y          : registered selected word
//   S_q        : select code captured together with Y
module mux_nbit
   import mux_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [N-1:0] C,
   input  logic [N-1:0] D,
   input  logic [1:0]   S,
   output logic [N-1:0] Y,
   output logic [1:0]   S_q
);

   generate
      if (N < MIN_WIDTH) begin : g_bad_width
         $error("mux_nbit: N must be at least 1");
      end
   endgenerate

   logic [N-1:0] sel;

   mux4_comb #(.N(N)) u_sel (
      .a (A),
      .b (B),
      .c (C),
      .d (D),
      .s (sel_t'(S)),
      .y (sel)
   );

   // Reset takes priority over a coincident enabled edge, discarding the load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Y   <= '0;
         S_q <= SEL_A;
      end else if (en) begin
         Y   <= sel;
         S_q <= S;
      end
   end

endmodule

// File: tb/tb_mux_nbit.sv
// Scoreboard bench for mux_nbit: the driver pushes hand-computed expected
// outputs per cycle; a monitor pops and compares one entry after each edge.
module tb_mux_nbit;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  S;
   logic [3:0]  A4, B4, C4, D4;
   logic [3:0]  Y4;
   logic [1:0]  Sq4;
   logic        A1, B1, C1, D1;
   logic        Y1;
   logic [1:0]  Sq1;
   logic [15:0] A16, B16, C16, D16;
   logic [15:0] Y16;
   logic [1:0]  Sq16;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [3:0]  y4;
      logic [1:0]  sq;
      logic        y1;
      logic [15:0] y16;
      bit          chk_w;
      int          tag;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   mux_nbit #(.N(4)) u4 (
      .clk(clk), .rst(rst), .en(en),
      .A(A4), .B(B4), .C(C4), .D(D4), .S(S), .Y(Y4), .S_q(Sq4)
   );

   mux_nbit #(.N(1)) u1 (
      .clk(clk), .rst(rst), .en(en),
      .A(A1), .B(B1), .C(C1), .D(D1), .S(S), .Y(Y1), .S_q(Sq1)
   );

   mux_nbit #(.N(16)) u16 (
      .clk(clk), .rst(rst), .en(en),
      .A(A16), .B(B16), .C(C16), .D(D16), .S(S), .Y(Y16), .S_q(Sq16)
   );

   task automatic chk(input string name, input int tag,
                      input logic [15:0] got, input logic [15:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s tag=%0d got=%h want=%h", name, tag, got, want);
   endtask

   // Monitor: compares the DUT against the oldest expectation after each edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("y4",  e.tag, {12'h0, Y4},  {12'h0, e.y4});
            chk("sq4", e.tag, {14'h0, Sq4}, {14'h0, e.sq});
            if (e.chk_w) begin
               chk("y1",   e.tag, {15'h0, Y1},  {15'h0, e.y1});
               chk("y16",  e.tag, Y16,          e.y16);
               chk("sq16", e.tag, {14'h0, Sq16}, {14'h0, e.sq});
            end
         end
      end
   end

   // One driven cycle for the N=4 instance; expectations are for the next edge.
   task automatic step(input logic r, input logic e, input logic [1:0] s,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d,
                       input logic [3:0] ey, input logic [1:0] es, input int tag);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; S = s;
      A4 = a; B4 = b; C4 = c; D4 = d;
      x.y4 = ey; x.sq = es; x.y1 = 1'b0; x.y16 = '0; x.chk_w = 1'b0; x.tag = tag;
      exp_q.push_back(x);
   endtask

   // Width cycle: N=4 data at defaults, N=1 / N=16 data fixed.
   task automatic wstep(input logic [1:0] s, input logic [3:0] ey4,
                        input logic ey1, input logic [15:0] ey16, input int tag);
      exp_t x;
      @(negedge clk);
      rst = 1'b0; en = 1'b1; S = s;
      A4 = 4'b0010; B4 = 4'b0110; C4 = 4'b1010; D4 = 4'b0011;
      x.y4 = ey4; x.sq = s; x.y1 = ey1; x.y16 = ey16; x.chk_w = 1'b1; x.tag = tag;
      exp_q.push_back(x);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; S = 2'b11;
      A4 = 4'b1111; B4 = 4'b1111; C4 = 4'b1111; D4 = 4'b1111;
      A1 = 1'b1; B1 = 1'b0; C1 = 1'b0; D1 = 1'b1;
      A16 = 16'hFFFF; B16 = 16'hAAAA; C16 = 16'h5555; D16 = 16'h0000;

      // Reset is asynchronous: outputs clear before any clock edge.
      #3;
      chk("rst_async_y4",  0, {12'h0, Y4},  16'h0);
      chk("rst_async_sq4", 0, {14'h0, Sq4}, 16'h0);
      chk("rst_async_y16", 0, Y16, 16'h0);
      chk("rst_async_y1",  0, {15'h0, Y1},  16'h0);
      // rst held across an enabled edge keeps everything cleared.
      #5;
      chk("rst_hold_y4",  0, {12'h0, Y4},  16'h0);
      chk("rst_hold_sq4", 0, {14'h0, Sq4}, 16'h0);

      // Select sweep; first step is the first loading edge after release.
      step(0, 1, 2'b00, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0010, 2'b00, 1);
      step(0, 1, 2'b01, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0110, 2'b01, 2);
      step(0, 1, 2'b10, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b1010, 2'b10, 3);
      step(0, 1, 2'b11, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0011, 2'b11, 4);

      // Unselected inputs have no effect; the selected one does.
      step(0, 1, 2'b01, 4'b1111, 4'b0110, 4'b0000, 4'b0101, 4'b0110, 2'b01, 5);
      step(0, 1, 2'b01, 4'b0000, 4'b0110, 4'b1111, 4'b1001, 4'b0110, 2'b01, 6);
      step(0, 1, 2'b01, 4'b0111, 4'b0110, 4'b0001, 4'b1110, 4'b0110, 2'b01, 7);
      step(0, 1, 2'b01, 4'b0111, 4'b1111, 4'b0001, 4'b1110, 4'b1111, 2'b01, 8);

      // Enable hold.
      step(0, 1, 2'b10, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b1010, 2'b10, 9);
      step(0, 0, 2'b11, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b1010, 2'b10, 10);
      step(0, 0, 2'b11, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b1010, 2'b10, 11);
      step(0, 0, 2'b11, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b1010, 2'b10, 12);
      step(0, 1, 2'b11, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0011, 2'b11, 13);

      // Reset pulse between edges clears Y immediately.
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_y4",  14, {12'h0, Y4},  16'h0);
      chk("rst_mid_sq4", 14, {14'h0, Sq4}, 16'h0);
      #1 rst = 1'b0;
      step(0, 1, 2'b10, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b1010, 2'b10, 15);
      // Reset wins over en on a coincident edge.
      step(1, 1, 2'b11, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0000, 2'b00, 16);
      step(0, 1, 2'b11, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0011, 2'b11, 17);

      // Width: N=1 (A=1,B=0,C=0,D=1) and N=16 (FFFF, AAAA, 5555, 0000).
      wstep(2'b00, 4'b0010, 1'b1, 16'hFFFF, 20);
      wstep(2'b01, 4'b0110, 1'b0, 16'hAAAA, 21);
      wstep(2'b10, 4'b1010, 1'b0, 16'h5555, 22);
      wstep(2'b11, 4'b0011, 1'b1, 16'h0000, 23);
      wstep(2'b10, 4'b1010, 1'b0, 16'h5555, 24);

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain pending=%0d want=0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
